// File: rtl/conv_axi_pkg.sv
// Shared definitions for the conv_bram AXI4-Lite control slave:
// register map, bit positions, response codes and FSM encodings.
package conv_axi_pkg;

  localparam int unsigned REG_CTRL_OFS   = 32'h0000_0000;
  localparam int unsigned REG_STATUS_OFS = 32'h0000_0004;
  localparam int unsigned REG_CYCLES_OFS = 32'h0000_0008;

  localparam int unsigned REG_CTRL_IDX   = REG_CTRL_OFS / 32'd4;
  localparam int unsigned REG_STATUS_IDX = REG_STATUS_OFS / 32'd4;
  localparam int unsigned REG_CYCLES_IDX = REG_CYCLES_OFS / 32'd4;

  localparam int unsigned CTRL_START_BIT   = 32'd0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 32'd1;
  localparam int unsigned STATUS_BUSY_BIT  = 32'd0;
  localparam int unsigned STATUS_DONE_BIT  = 32'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_DATA = 2'b10
  } rd_state_e;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/conv_axi_regs.sv
// CTRL/STATUS/CYCLES register block: start pulse generation, core done
// edge detection, busy/done tracking and interrupt level.
module conv_axi_regs
  import conv_axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_BW = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [AXI_ADDR_BW-1:0] wr_idx_i,
  input  logic [31:0]            wr_data_i,
  output logic                   wr_err_o,
  input  logic [AXI_ADDR_BW-1:0] rd_idx_i,
  output logic [31:0]            rd_data_o,
  input  logic                   done_i,
  output logic                   busy_o,
  output logic                   w_done_o,
  output logic                   irq_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic        w_done_q, w_done_d;
  logic        irq_q, irq_d;
  logic        done_prev_q;
  logic [31:0] cycles_q, cycles_d;

  logic wr_ctrl_s, wr_status_s, start_req_s, start_s, rise_s;
  logic unused_s;

  assign unused_s = ^wr_data_i[31:2];

  always_comb begin
    wr_ctrl_s   = wr_en_i && (wr_idx_i == AXI_ADDR_BW'(REG_CTRL_IDX));
    wr_status_s = wr_en_i && (wr_idx_i == AXI_ADDR_BW'(REG_STATUS_IDX));
    start_req_s = wr_ctrl_s && wr_data_i[CTRL_START_BIT];
    start_s     = start_req_s && !busy_q;
    wr_err_o    = start_req_s && busy_q;
    rise_s      = done_i && !done_prev_q && busy_q;

    busy_d   = busy_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    cycles_d = cycles_q;

    // A rejected START write leaves the whole CTRL register untouched.
    if (wr_ctrl_s && !wr_err_o) begin
      irq_en_d = wr_data_i[CTRL_IRQ_EN_BIT];
    end else begin
      irq_en_d = irq_en_q;
    end

    if (start_s) begin
      busy_d   = 1'b1;
      done_d   = 1'b0;
      cycles_d = 32'd0;
    end else if (rise_s) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      cycles_d = sat_inc32(cycles_q);
    end else begin
      busy_d = busy_q;
      if (busy_q) begin
        cycles_d = sat_inc32(cycles_q);
      end else begin
        cycles_d = cycles_q;
      end
      if (wr_status_s && wr_data_i[STATUS_DONE_BIT]) begin
        done_d = 1'b0;
      end else begin
        done_d = done_q;
      end
    end

    w_done_d = start_s;
    irq_d    = done_d && irq_en_d;
  end

  always_comb begin
    rd_data_o = 32'd0;
    if (rd_idx_i == AXI_ADDR_BW'(REG_CTRL_IDX)) begin
      rd_data_o[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (rd_idx_i == AXI_ADDR_BW'(REG_STATUS_IDX)) begin
      rd_data_o[STATUS_BUSY_BIT] = busy_q;
      rd_data_o[STATUS_DONE_BIT] = done_q;
    end else if (rd_idx_i == AXI_ADDR_BW'(REG_CYCLES_IDX)) begin
      rd_data_o = cycles_q;
    end else begin
      rd_data_o = 32'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      w_done_q    <= 1'b0;
      irq_q       <= 1'b0;
      done_prev_q <= 1'b0;
      cycles_q    <= 32'd0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      w_done_q    <= w_done_d;
      irq_q       <= irq_d;
      done_prev_q <= done_i;
      cycles_q    <= cycles_d;
    end
  end

  assign busy_o   = busy_q;
  assign w_done_o = w_done_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/conv_axi_ctrl.sv
// AXI4-Lite slave in front of the conv_bram core: register window plus a
// memory window onto the host BRAM port, with write-over-read arbitration.
module conv_axi_ctrl
  import conv_axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_BW = 8,
  parameter int unsigned AXI_DATA_BW = 32,
  parameter int unsigned S_ADDR_BW   = AXI_ADDR_BW + 3
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [S_ADDR_BW-1:0]     S_AWADDR,
  input  logic                     S_AWVALID,
  output logic                     S_AWREADY,
  input  logic [AXI_DATA_BW-1:0]   S_WDATA,
  input  logic [AXI_DATA_BW/8-1:0] S_WSTRB,
  input  logic                     S_WVALID,
  output logic                     S_WREADY,
  output logic [1:0]               S_BRESP,
  output logic                     S_BVALID,
  input  logic                     S_BREADY,
  input  logic [S_ADDR_BW-1:0]     S_ARADDR,
  input  logic                     S_ARVALID,
  output logic                     S_ARREADY,
  output logic [AXI_DATA_BW-1:0]   S_RDATA,
  output logic [1:0]               S_RRESP,
  output logic                     S_RVALID,
  input  logic                     S_RREADY,
  output logic [AXI_ADDR_BW-1:0]   o_bram_addr,
  output logic                     o_bram_en,
  output logic [AXI_DATA_BW/8-1:0] o_bram_we,
  output logic [AXI_DATA_BW-1:0]   o_bram_wdata,
  input  logic [AXI_DATA_BW-1:0]   i_bram_rdata,
  output logic                     o_w_done,
  input  logic                     i_done,
  output logic                     o_irq
);

  wr_state_e                w_state_q;
  logic                     awready_q, bvalid_q;
  logic [1:0]               bresp_q;
  logic                     wr_bram_q, wr_err_q;
  logic [AXI_ADDR_BW-1:0]   wr_idx_q;
  logic [AXI_DATA_BW-1:0]   wr_data_q;

  rd_state_e                r_state_q;
  logic                     arready_q, rvalid_q;
  logic [1:0]               rresp_q;
  logic [AXI_DATA_BW-1:0]   rdata_q;
  logic                     rd_bram_q, rd_err_q;
  logic [AXI_ADDR_BW-1:0]   rd_idx_q;

  logic                     bram_en_q;
  logic [AXI_DATA_BW/8-1:0] bram_we_q;
  logic [AXI_ADDR_BW-1:0]   bram_addr_q;
  logic [AXI_DATA_BW-1:0]   bram_wdata_q;

  logic                     aw_bram_s, ar_bram_s, w_start_s, r_start_s;
  logic [AXI_ADDR_BW-1:0]   aw_idx_s, ar_idx_s;
  logic                     reg_wr_en_s, reg_wr_err_s, busy_s;
  logic [31:0]              reg_rdata_s;
  logic                     unused_s;

  assign unused_s = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  // A write request seen this cycle claims the BRAM port for next cycle,
  // so a read request in the same cycle waits.
  always_comb begin
    aw_bram_s   = S_AWADDR[S_ADDR_BW-1];
    ar_bram_s   = S_ARADDR[S_ADDR_BW-1];
    aw_idx_s    = S_AWADDR[AXI_ADDR_BW+1:2];
    ar_idx_s    = S_ARADDR[AXI_ADDR_BW+1:2];
    w_start_s   = (w_state_q == W_IDLE) && !awready_q && !bvalid_q &&
                  S_AWVALID && S_WVALID;
    r_start_s   = (r_state_q == R_IDLE) && !arready_q && S_ARVALID && !w_start_s;
    reg_wr_en_s = awready_q && !wr_bram_q;
  end

  conv_axi_regs #(
    .AXI_ADDR_BW (AXI_ADDR_BW)
  ) u_regs (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .wr_en_i   (reg_wr_en_s),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (wr_data_q),
    .wr_err_o  (reg_wr_err_s),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (reg_rdata_s),
    .done_i    (i_done),
    .busy_o    (busy_s),
    .w_done_o  (o_w_done),
    .irq_o     (o_irq)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_bram_q <= 1'b0;
      wr_err_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (wr_bram_q ? wr_err_q : reg_wr_err_s) ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end else if (w_start_s) begin
            awready_q <= 1'b1;
            wr_bram_q <= aw_bram_s;
            wr_err_q  <= aw_bram_s && busy_s;
            wr_idx_q  <= aw_idx_s;
            wr_data_q <= S_WDATA;
          end else begin
            awready_q <= 1'b0;
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            w_state_q <= W_IDLE;
          end else begin
            bvalid_q  <= 1'b1;
          end
        end
        default: begin
          awready_q <= 1'b0;
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_bram_q <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            r_state_q <= R_WAIT;
          end else if (r_start_s) begin
            arready_q <= 1'b1;
            rd_bram_q <= ar_bram_s;
            rd_err_q  <= ar_bram_s && busy_s;
            rd_idx_q  <= ar_idx_s;
          end else begin
            arready_q <= 1'b0;
          end
        end
        R_WAIT: begin
          rvalid_q  <= 1'b1;
          rresp_q   <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
          rdata_q   <= rd_err_q ? '0 : (rd_bram_q ? i_bram_rdata : reg_rdata_s);
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (S_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            rvalid_q  <= 1'b1;
          end
        end
        default: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // BRAM accesses are refused while the core owns the memory.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else if (w_start_s && aw_bram_s && !busy_s) begin
      bram_en_q    <= 1'b1;
      bram_we_q    <= S_WSTRB;
      bram_addr_q  <= aw_idx_s;
      bram_wdata_q <= S_WDATA;
    end else if (r_start_s && ar_bram_s && !busy_s) begin
      bram_en_q    <= 1'b1;
      bram_we_q    <= '0;
      bram_addr_q  <= ar_idx_s;
    end else begin
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
    end
  end

  assign S_AWREADY    = awready_q;
  assign S_WREADY     = awready_q;
  assign S_BVALID     = bvalid_q;
  assign S_BRESP      = bresp_q;
  assign S_ARREADY    = arready_q;
  assign S_RVALID     = rvalid_q;
  assign S_RRESP      = rresp_q;
  assign S_RDATA      = rdata_q;
  assign o_bram_en    = bram_en_q;
  assign o_bram_we    = bram_we_q;
  assign o_bram_addr  = bram_addr_q;
  assign o_bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_conv_axi_ctrl.sv
// Directed self-checking bench for conv_axi_ctrl with a simple BRAM model.
module tb_conv_axi_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [10:0] S_AWADDR;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID, S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID, S_BREADY;
  logic [10:0] S_ARADDR;
  logic        S_ARVALID, S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID, S_RREADY;
  logic [7:0]  o_bram_addr;
  logic        o_bram_en;
  logic [3:0]  o_bram_we;
  logic [31:0] o_bram_wdata;
  logic [31:0] i_bram_rdata;
  logic        o_w_done;
  logic        i_done;
  logic        o_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wdone_cnt = 0;
  logic [31:0] mem [0:255];

  conv_axi_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .o_bram_addr(o_bram_addr), .o_bram_en(o_bram_en), .o_bram_we(o_bram_we),
    .o_bram_wdata(o_bram_wdata), .i_bram_rdata(i_bram_rdata),
    .o_w_done(o_w_done), .i_done(i_done), .o_irq(o_irq)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) if (o_w_done) wdone_cnt <= wdone_cnt + 1;

  // Host BRAM port: byte-enabled write, one-cycle read latency.
  always @(posedge ACLK) begin
    if (o_bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (o_bram_we[b]) mem[o_bram_addr][8*b +: 8] <= o_bram_wdata[8*b +: 8];
      end
      i_bram_rdata <= mem[o_bram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic en, output logic [3:0] we,
                           output logic [7:0] baddr, output logic [31:0] bwd,
                           output int acc_cyc);
    int n;
    S_AWADDR = addr; S_AWVALID = 1'b1;
    S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AWREADY && n < 20);
    chk("aw_handshake", {31'd0, S_AWREADY & S_WREADY}, 32'd1);
    en = o_bram_en; we = o_bram_we; baddr = o_bram_addr; bwd = o_bram_wdata;
    acc_cyc = cyc;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    n = 0;
    while (!S_BVALID && n < 20) begin @(negedge ACLK); n++; end
    chk("bvalid", {31'd0, S_BVALID}, 32'd1);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [10:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output int ar_cyc);
    int n;
    S_ARADDR = addr; S_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_ARREADY && n < 20);
    chk("ar_handshake", {31'd0, S_ARREADY}, 32'd1);
    ar_cyc = cyc;
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!S_RVALID && lat < 20);
    chk("rvalid", {31'd0, S_RVALID}, 32'd1);
    data = S_RDATA; resp = S_RRESP;
    S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_RREADY = 1'b0;
  endtask

  logic [1:0]  resp, resp2;
  logic        en;
  logic [3:0]  we;
  logic [7:0]  ba;
  logic [31:0] wd, rd;
  int          acc, arc, lat, start_cyc, n;

  initial begin
    ARESETn = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
    S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0; i_done = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", {31'd0, S_AWREADY}, 32'd0);
    chk("rst_arready", {31'd0, S_ARREADY}, 32'd0);
    chk("rst_bvalid", {31'd0, S_BVALID}, 32'd0);
    chk("rst_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("rst_rdata", S_RDATA, 32'd0);
    chk("rst_bram_en", {31'd0, o_bram_en}, 32'd0);
    chk("rst_bram_we", {28'd0, o_bram_we}, 32'd0);
    chk("rst_w_done", {31'd0, o_w_done}, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    axi_read(11'h004, rd, resp, lat, arc);
    chk("status_after_rst", rd, 32'd0);
    chk("status_rresp", {30'd0, resp}, 32'd0);
    chk("reg_rd_latency", lat, 32'd2);

    axi_write(11'h414, 32'hDEAD_BEEF, 4'hF, resp, en, we, ba, wd, acc);
    chk("bram_wr_en", {31'd0, en}, 32'd1);
    chk("bram_wr_we", {28'd0, we}, 32'h0000_000F);
    chk("bram_wr_addr", {24'd0, ba}, 32'd5);
    chk("bram_wr_data", wd, 32'hDEAD_BEEF);
    chk("bram_wr_bresp", {30'd0, resp}, 32'd0);
    axi_read(11'h414, rd, resp, lat, arc);
    chk("bram_rd_data", rd, 32'hDEAD_BEEF);
    chk("bram_rd_rresp", {30'd0, resp}, 32'd0);
    chk("bram_rd_latency", lat, 32'd2);

    axi_write(11'h414, 32'h1234_5678, 4'b0011, resp, en, we, ba, wd, acc);
    chk("bram_part_we", {28'd0, we}, 32'h0000_0003);
    axi_read(11'h414, rd, resp, lat, arc);
    chk("bram_part_data", rd, 32'hDEAD_5678);

    axi_write(11'h00C, 32'hFFFF_FFFF, 4'hF, resp, en, we, ba, wd, acc);
    chk("unmapped_bresp", {30'd0, resp}, 32'd0);
    axi_read(11'h00C, rd, resp, lat, arc);
    chk("unmapped_rdata", rd, 32'd0);
    chk("unmapped_rresp", {30'd0, resp}, 32'd0);

    // Run 1: start with IRQ enabled
    axi_write(11'h000, 32'h0000_0003, 4'hF, resp, en, we, ba, wd, start_cyc);
    chk("start_bresp", {30'd0, resp}, 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    chk("start_pulse_cnt", wdone_cnt, 32'd1);
    axi_read(11'h004, rd, resp, lat, arc);
    chk("status_busy", rd, 32'h0000_0001);
    axi_read(11'h000, rd, resp, lat, arc);
    chk("ctrl_readback", rd, 32'h0000_0002);

    axi_write(11'h418, 32'hCAFE_F00D, 4'hF, resp, en, we, ba, wd, acc);
    chk("busy_bram_bresp", {30'd0, resp}, 32'h0000_0002);
    chk("busy_bram_we", {28'd0, we}, 32'd0);
    axi_read(11'h418, rd, resp, lat, arc);
    chk("busy_bram_rdata", rd, 32'd0);
    chk("busy_bram_rresp", {30'd0, resp}, 32'h0000_0002);
    axi_write(11'h000, 32'h0000_0003, 4'hF, resp, en, we, ba, wd, acc);
    chk("busy_start_bresp", {30'd0, resp}, 32'h0000_0002);
    repeat (2) @(posedge ACLK);
    #1;
    chk("busy_start_no_pulse", wdone_cnt, 32'd1);

    while (cyc < start_cyc + 100) begin @(posedge ACLK); #1; end
    i_done = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("irq_on_done", {31'd0, o_irq}, 32'd1);
    axi_read(11'h004, rd, resp, lat, arc);
    chk("status_done", rd, 32'h0000_0002);
    axi_read(11'h008, rd, resp, lat, arc);
    chk("cycles_range", {31'd0, (rd >= 32'd99) && (rd <= 32'd102)}, 32'd1);

    axi_write(11'h004, 32'h0000_0002, 4'hF, resp, en, we, ba, wd, acc);
    @(negedge ACLK);
    chk("irq_cleared", {31'd0, o_irq}, 32'd0);
    axi_read(11'h004, rd, resp, lat, arc);
    chk("status_cleared", rd, 32'd0);

    // Run 2: i_done already high, so only a fresh edge may finish it
    axi_write(11'h000, 32'h0000_0003, 4'hF, resp, en, we, ba, wd, acc);
    repeat (5) @(posedge ACLK);
    #1;
    axi_read(11'h004, rd, resp, lat, arc);
    chk("level_no_edge", rd, 32'h0000_0001);
    chk("second_pulse_cnt", wdone_cnt, 32'd2);
    i_done = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    fork
      axi_write(11'h004, 32'h0000_0002, 4'hF, resp, en, we, ba, wd, acc);
      begin @(posedge ACLK); #1; i_done = 1'b1; end
    join
    axi_read(11'h004, rd, resp, lat, arc);
    chk("clear_vs_rise", rd, 32'h0000_0002);
    chk("irq_after_race", {31'd0, o_irq}, 32'd1);

    fork
      axi_write(11'h41C, 32'h0BAD_F00D, 4'hF, resp2, en, we, ba, wd, acc);
      axi_read(11'h414, rd, resp, lat, arc);
    join
    chk("arb_bresp", {30'd0, resp2}, 32'd0);
    chk("arb_rdata", rd, 32'hDEAD_5678);
    chk("arb_rresp", {30'd0, resp}, 32'd0);
    chk("arb_ar_delay", arc - acc, 32'd1);
    axi_read(11'h41C, rd, resp, lat, arc);
    chk("arb_wr_landed", rd, 32'h0BAD_F00D);

    // Run 3: reset while a read response is pending
    i_done = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    axi_write(11'h000, 32'h0000_0001, 4'hF, resp, en, we, ba, wd, acc);
    S_ARADDR = 11'h004; S_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_ARREADY && n < 20);
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_RVALID && n < 20);
    chk("pend_rvalid", {31'd0, S_RVALID}, 32'd1);
    chk("pend_rdata", S_RDATA, 32'h0000_0001);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("arst_rdata", S_RDATA, 32'd0);
    chk("arst_busy", {31'd0, dut.u_regs.busy_q}, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_rvalid", {31'd0, S_RVALID}, 32'd0);
    @(posedge ACLK); #1;
    axi_read(11'h008, rd, resp, lat, arc);
    chk("post_rst_cycles", rd, 32'd0);
    axi_read(11'h004, rd, resp, lat, arc);
    chk("post_rst_status", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_axi_ctrl.md
Name: conv_axi_ctrl

Overview:
AXI4-Lite slave that sits directly upstream of the conv_bram accelerator core. It gives the host a register window (start, status, cycle counter) and a memory window onto a single host BRAM port, through which input data and weights are loaded and results read back. It issues the i_w_done start pulse to the core and observes its o_done to track busy/done state.

Parameters:
AXI_ADDR_BW, 8, BRAM word-address width (matches conv_bram)
AXI_DATA_BW, 32, AXI and BRAM data width; fixed 32 (WSTRB 4 bits)
S_ADDR_BW, AXI_ADDR_BW+3, AXI byte-address width; MSB selects region

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
S_AWADDR/S_AWVALID/S_AWREADY  in/in/out  S_ADDR_BW/1/1  write address channel
S_WDATA/S_WSTRB/S_WVALID/S_WREADY  in/in/in/out  32/4/1/1  write data channel
S_BRESP/S_BVALID/S_BREADY  out/out/in  2/1/1  write response
S_ARADDR/S_ARVALID/S_ARREADY  in/in/out  S_ADDR_BW/1/1  read address
S_RDATA/S_RRESP/S_RVALID/S_RREADY  out/out/out/in  32/2/1/1  read data
o_bram_addr  out  AXI_ADDR_BW  host BRAM word address
o_bram_en  out  1  host BRAM enable
o_bram_we  out  4  host BRAM byte write enables
o_bram_wdata  out  32  host BRAM write data
i_bram_rdata  in  32  host BRAM read data, valid 1 cycle after o_bram_en
o_w_done  out  1  one-cycle start pulse to core i_w_done
i_done  in  1  core o_done (level)
o_irq  out  1  level, equals STATUS.DONE & CTRL.IRQ_EN

Behaviour:
- Region: addr[S_ADDR_BW-1]=0 registers, =1 BRAM; word index addr[AXI_ADDR_BW+1:2]; addr[1:0] ignored.
- Registers: 0x00 CTRL (bit0 START, write-1 action, reads 0; bit1 IRQ_EN rw). 0x04 STATUS (bit0 BUSY ro; bit1 DONE sticky, write-1-clears). 0x08 CYCLES (ro, 32-bit). Other offsets read 0/OKAY; writes ignored/OKAY.
- Reset: all READY/VALID low, BRESP/RRESP/RDATA 0, o_bram_* 0, o_w_done 0, BUSY/DONE/IRQ_EN 0, CYCLES 0, o_irq 0.
- Write FSM W_IDLE->W_RESP: AWREADY and WREADY asserted together for exactly one cycle when AWVALID&WVALID both high and BVALID low; the action occurs that cycle; BVALID high next cycle, held until BREADY. No AW-only or W-only acceptance.
- Read FSM R_IDLE->R_WAIT->R_DATA: ARREADY pulsed for one cycle on ARVALID (when no read is outstanding); BRAM read issued that cycle; RDATA latched in R_WAIT; RVALID held in R_DATA until RREADY. Register reads follow the same 2-cycle latency.
- Port arbitration: write accepted in the same cycle as a read request -> write wins, ARREADY withheld one cycle.
- BRAM write: o_bram_en=1, o_bram_we=S_WSTRB, single cycle. When BUSY=1, BRAM writes are dropped (we=0) with BRESP=SLVERR(2'b10); BRAM reads while BUSY return RDATA 0 with RRESP=SLVERR.
- START write with BUSY=0: o_w_done pulses 1 cycle after acceptance; BUSY<=1, DONE<=0, CYCLES<=0. With BUSY=1: ignored, SLVERR.
- CYCLES increments every cycle while BUSY and saturates at 0xFFFFFFFF.
- i_done rising edge (registered previous value) while BUSY: BUSY<=0, DONE<=1. i_done level high without an edge has no effect. DONE clear and a rising edge in the same cycle -> DONE stays 1.
- Reset mid-transaction aborts all state; no response is produced for accepted-but-unanswered requests.

Decomposition:
- Package conv_axi_pkg: register offsets, CTRL/STATUS bit indices, RESP_OKAY/RESP_SLVERR, FSM state encodings.
- Natural sub-module: conv_axi_regs (CTRL/STATUS/CYCLES, edge detect, start pulse); the AXI FSMs and BRAM mux stay in the top module.

Test Plan:
- Reset, then read 0x04 -> RDATA 0, RRESP 0; o_w_done, o_irq, o_bram_en all 0.
- Write 0xDEADBEEF, WSTRB 0xF to BRAM word 5 (byte addr 0x414 for default) -> o_bram_we=4'hF, addr 5; readback gives 0xDEADBEEF two cycles after ARREADY.
- Write CTRL=0x3 -> one o_w_done pulse, STATUS=0x1; hold i_done low 100 cycles, raise it -> STATUS=0x2, CYCLES≈100+1, o_irq=1; write STATUS=0x2 -> o_irq=0.
- During BUSY: BRAM write -> BRESP 2'b10, we stays 0; START write -> SLVERR, no pulse.
- Simultaneous AW/W and AR in one cycle -> write completes first, ARREADY one cycle later, both responses correct.
- Assert ARESETn low while RVALID is pending -> RVALID 0, BUSY 0 immediately (asynchronous).
